// File: rtl/emu_dt_sched.sv
// emu_dt_sched: emulation time-step scheduler.
// Selects the smallest dt request each cycle and gates it by the host control
// mode (free-run, hold, run-to-time, run-N-steps). Owns emu_time and emu_dt.
// Optional feature: define EMU_DT_SCHED_STATS_EN to build the stall_cycles
// counter; otherwise stall_cycles reads 0 and no counter exists.
module emu_dt_sched #(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned DT_WIDTH   = 32,
  parameter int unsigned TIME_WIDTH = 64
) (
  input  logic                      emu_clk,
  input  logic                      emu_rst,
  input  logic [N_REQ*DT_WIDTH-1:0] dt_req,
  input  logic [1:0]                ctrl_mode,
  input  logic [TIME_WIDTH-1:0]     ctrl_data,
  output logic [DT_WIDTH-1:0]       emu_dt,
  output logic [TIME_WIDTH-1:0]     emu_time,
  output logic [N_REQ-1:0]          dt_grant,
  output logic                      running,
  output logic                      done,
  output logic [31:0]               stall_cycles
);

  localparam logic [1:0] MODE_FREE  = 2'd0;
  localparam logic [1:0] MODE_HOLD  = 2'd1;
  localparam logic [1:0] MODE_RUNTO = 2'd2;
  localparam logic [1:0] MODE_RUNN  = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StFree,
    StHold,
    StRunTo,
    StRunN,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [TIME_WIDTH-1:0] tgt_q, tgt_d;
  logic [TIME_WIDTH-1:0] cnt_q, cnt_d;
  logic [TIME_WIDTH-1:0] time_q;
  logic [DT_WIDTH-1:0]   dt_q;
  logic [N_REQ-1:0]      grant_q;
  logic                  done_q;

  logic [DT_WIDTH-1:0]   dmin;
  logic [N_REQ-1:0]      dmin_grant;
  logic [DT_WIDTH-1:0]   dsel;
  logic [N_REQ-1:0]      gsel;
  logic [TIME_WIDTH-1:0] rem_full;
  logic [TIME_WIDTH-1:0] dt_max_ext;
  logic [DT_WIDTH-1:0]   rem_clamp;

  // Minimum request; strict less-than keeps the lowest index on ties.
  always_comb begin
    dmin       = dt_req[DT_WIDTH-1:0];
    dmin_grant = N_REQ'(1);
    for (int i = 1; i < N_REQ; i++) begin
      if (dt_req[i*DT_WIDTH +: DT_WIDTH] < dmin) begin
        dmin       = dt_req[i*DT_WIDTH +: DT_WIDTH];
        dmin_grant = N_REQ'(1) << i;
      end
    end
  end

  // Distance to target, clamped to the largest representable step.
  assign rem_full   = tgt_q - time_q;
  assign dt_max_ext = TIME_WIDTH'({DT_WIDTH{1'b1}});
  assign rem_clamp  = (rem_full > dt_max_ext) ? {DT_WIDTH{1'b1}} : rem_full[DT_WIDTH-1:0];

  // Next state, latched control values and the step applied this cycle.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    dsel    = '0;
    gsel    = '0;
    unique case (state_q)
      StFree: begin
        dsel = dmin;
        gsel = dmin_grant;
      end
      StRunTo: begin
        // A step shortened by the target was not set by any requester.
        if (dmin <= rem_clamp) begin
          dsel = dmin;
          gsel = dmin_grant;
        end else begin
          dsel = rem_clamp;
        end
        if (rem_full == TIME_WIDTH'(dsel)) state_d = StDone;
      end
      StRunN: begin
        if (cnt_q != '0) begin
          dsel = dmin;
          gsel = dmin_grant;
          // Zero-dt cycles do not consume a step.
          if (dmin != '0) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == TIME_WIDTH'(1)) state_d = StDone;
          end
        end
      end
      StArm: begin
        mode_d = ctrl_mode;
        unique case (ctrl_mode)
          MODE_FREE: state_d = StFree;
          MODE_HOLD: state_d = StHold;
          MODE_RUNTO: begin
            tgt_d   = ctrl_data;
            state_d = (ctrl_data <= time_q) ? StDone : StRunTo;
          end
          MODE_RUNN: begin
            cnt_d   = ctrl_data;
            state_d = (ctrl_data == '0) ? StDone : StRunN;
          end
          default: state_d = StHold;
        endcase
      end
      StIdle, StHold, StDone: ;
      default: state_d = StIdle;
    endcase
    // Any mode change re-arms; ARM itself latches whatever mode is present.
    if (state_q != StArm && ctrl_mode != mode_q) state_d = StArm;
  end

  // State, control latches and the registered step/time/grant outputs.
  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      state_q <= StIdle;
      mode_q  <= MODE_HOLD;
      tgt_q   <= '0;
      cnt_q   <= '0;
      dt_q    <= '0;
      time_q  <= '0;
      grant_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      dt_q    <= dsel;
      time_q  <= time_q + TIME_WIDTH'(dsel);
      grant_q <= gsel;
      done_q  <= (state_d == StDone) && (state_q != StDone);
    end
  end

  assign emu_dt   = dt_q;
  assign emu_time = time_q;
  assign dt_grant = grant_q;
  assign done     = done_q;
  assign running  = (state_q == StFree) || (state_q == StRunTo) || (state_q == StRunN);

`ifdef EMU_DT_SCHED_STATS_EN
  logic [31:0] stall_q;

  // Saturating count of zero-step cycles outside IDLE.
  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      stall_q <= '0;
    end else if (state_q != StIdle && dsel == '0 && stall_q != 32'hFFFF_FFFF) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_emu_dt_sched.sv
// Self-checking bench for emu_dt_sched (default parameters, N_REQ = 2).
// Directed table, hand-written corner sequences, then random stimulus against
// a rule-level reference model.
module tb_emu_dt_sched;

  localparam logic [1:0] FR = 2'd0;
  localparam logic [1:0] HO = 2'd1;
  localparam logic [1:0] RT = 2'd2;
  localparam logic [1:0] RN = 2'd3;

  logic        emu_clk = 1'b0;
  logic        emu_rst;
  logic [63:0] dt_req;
  logic [1:0]  ctrl_mode;
  logic [63:0] ctrl_data;
  logic [31:0] emu_dt;
  logic [63:0] emu_time;
  logic [1:0]  dt_grant;
  logic        running;
  logic        done;
  logic [31:0] stall_cycles;

  int unsigned cur_r0, cur_r1;
  int total = 0;
  int bad   = 0;

  assign dt_req = {cur_r1, cur_r0};

  emu_dt_sched dut (
    .emu_clk      (emu_clk),
    .emu_rst      (emu_rst),
    .dt_req       (dt_req),
    .ctrl_mode    (ctrl_mode),
    .ctrl_data    (ctrl_data),
    .emu_dt       (emu_dt),
    .emu_time     (emu_time),
    .dt_grant     (dt_grant),
    .running      (running),
    .done         (done),
    .stall_cycles (stall_cycles)
  );

  always #5 emu_clk = ~emu_clk;

  typedef struct {
    logic [1:0]      mode;
    int unsigned     r0;
    int unsigned     r1;
    longint unsigned data;
    int unsigned     dt;
    longint unsigned tm;
    logic [1:0]      g;
    bit              chk_g;
    bit              run;
    bit              dn;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [1:0] mode, int unsigned r0, int unsigned r1,
                              longint unsigned data, int unsigned dt, longint unsigned tm,
                              logic [1:0] g, bit chk_g, bit run, bit dn);
    vec_t v;
    v.mode = mode; v.r0 = r0; v.r1 = r1; v.data = data; v.dt = dt; v.tm = tm;
    v.g = g; v.chk_g = chk_g; v.run = run; v.dn = dn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] mode, input int unsigned r0, input int unsigned r1,
                       input longint unsigned data);
    ctrl_mode = mode;
    cur_r0    = r0;
    cur_r1    = r1;
    ctrl_data = data;
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge emu_clk);
    #1;
  endtask

  // Reference model: scheduler described by its mode rules.
  logic [1:0]      m_mode;
  bit              m_idle, m_arm, m_fin, m_done, m_run, m_gchk;
  longint unsigned m_time, m_tgt, m_cnt;
  int unsigned     m_dt, m_stall;
  logic [1:0]      m_grant;

  task automatic model_reset();
    m_mode = HO; m_idle = 1; m_arm = 0; m_fin = 0; m_done = 0; m_run = 0; m_gchk = 1;
    m_time = 0; m_tgt = 0; m_cnt = 0; m_dt = 0; m_stall = 0; m_grant = 0;
  endtask

  task automatic model_edge();
    int unsigned     dmin, step;
    int              gi;
    longint unsigned rem, lim;
    bit              fin_now, stall_ok;
    dmin = cur_r0; gi = 0;
    if (cur_r1 < dmin) begin dmin = cur_r1; gi = 1; end
    step = 0; fin_now = 0; m_gchk = 1; m_grant = 0;
    stall_ok = !(m_idle && !m_arm);
    if (m_arm) begin
      m_arm = 0; m_idle = 0; m_fin = 0; m_mode = ctrl_mode;
      if (ctrl_mode == RT) begin
        m_tgt = ctrl_data;
        fin_now = (ctrl_data <= m_time);
      end else if (ctrl_mode == RN) begin
        m_cnt = ctrl_data;
        fin_now = (ctrl_data == 0);
      end
    end else begin
      if (!m_idle && !m_fin) begin
        if (m_mode == FR) begin
          step = dmin; m_grant = 2'(1 << gi);
        end else if (m_mode == RT) begin
          rem = m_tgt - m_time;
          lim = (rem > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : rem;
          if (longint'(dmin) <= lim) begin
            step = dmin; m_grant = 2'(1 << gi);
          end else begin
            step = int'(lim); m_gchk = 0;
          end
          fin_now = (m_time + step == m_tgt);
        end else if (m_mode == RN) begin
          step = dmin; m_grant = 2'(1 << gi);
          if (dmin != 0) begin
            m_cnt--;
            fin_now = (m_cnt == 0);
          end
        end
      end
      if (ctrl_mode != m_mode) begin
        m_arm = 1; fin_now = 0;
      end
    end
    if (fin_now) m_fin = 1;
    m_done = fin_now;
    m_dt = step;
    m_time += step;
    if (step == 0 && stall_ok && m_stall != 32'hFFFF_FFFF) m_stall++;
    m_run = !m_arm && !m_idle && !m_fin && (m_mode != HO);
  endtask

  initial begin
    int unsigned     exp_stall;
    longint unsigned far_tgt;

    // Test plan order: r0 listed first.
    tbl.push_back(mk(HO, 10, 4, 0,  0,  0, 2'b00, 1, 0, 0));
    tbl.push_back(mk(FR, 10, 4, 0,  0,  0, 2'b00, 1, 0, 0));
    tbl.push_back(mk(FR, 10, 4, 0,  0,  0, 2'b00, 1, 1, 0));
    tbl.push_back(mk(FR, 10, 4, 0,  4,  4, 2'b10, 1, 1, 0));
    tbl.push_back(mk(FR, 10, 4, 0,  4,  8, 2'b10, 1, 1, 0));
    tbl.push_back(mk(FR, 10, 4, 0,  4, 12, 2'b10, 1, 1, 0));
    tbl.push_back(mk(FR,  7, 7, 0,  7, 19, 2'b01, 1, 1, 0));
    tbl.push_back(mk(FR,  0, 7, 0,  0, 19, 2'b01, 1, 1, 0));
    tbl.push_back(mk(HO,  4, 4, 0,  4, 23, 2'b01, 1, 0, 0));
    tbl.push_back(mk(HO,  4, 4, 0,  0, 23, 2'b00, 1, 0, 0));
    tbl.push_back(mk(HO,  4, 4, 0,  0, 23, 2'b00, 1, 0, 0));
    tbl.push_back(mk(RT,  4, 4, 33, 0, 23, 2'b00, 1, 0, 0));
    tbl.push_back(mk(RT,  4, 4, 33, 0, 23, 2'b00, 1, 1, 0));
    tbl.push_back(mk(RT,  4, 4, 33, 4, 27, 2'b01, 1, 1, 0));
    tbl.push_back(mk(RT,  4, 4, 33, 4, 31, 2'b01, 1, 1, 0));
    tbl.push_back(mk(RT,  4, 4, 33, 2, 33, 2'b00, 0, 0, 1));
    tbl.push_back(mk(RT,  4, 4, 33, 0, 33, 2'b00, 1, 0, 0));
    tbl.push_back(mk(HO,  4, 4, 0,  0, 33, 2'b00, 1, 0, 0));
    tbl.push_back(mk(HO,  4, 4, 0,  0, 33, 2'b00, 1, 0, 0));
    tbl.push_back(mk(RN,  5, 9, 3,  0, 33, 2'b00, 1, 0, 0));
    tbl.push_back(mk(RN,  5, 9, 3,  0, 33, 2'b00, 1, 1, 0));
    tbl.push_back(mk(RN,  5, 9, 3,  5, 38, 2'b01, 1, 1, 0));
    tbl.push_back(mk(RN,  0, 9, 3,  0, 38, 2'b01, 1, 1, 0));
    tbl.push_back(mk(RN,  5, 9, 3,  5, 43, 2'b01, 1, 1, 0));
    tbl.push_back(mk(RN,  0, 9, 3,  0, 43, 2'b01, 1, 1, 0));
    tbl.push_back(mk(RN,  5, 9, 3,  5, 48, 2'b01, 1, 0, 1));
    tbl.push_back(mk(RN,  5, 9, 3,  0, 48, 2'b00, 1, 0, 0));

    // Reset with HOLD applied.
    emu_rst = 1'b1;
    drive(HO, 10, 4, 0);
    #22;
    chk("rst_dt", 64'(emu_dt), 0);
    chk("rst_time", emu_time, 0);
    chk("rst_grant", 64'(dt_grant), 0);
    chk("rst_running", 64'(running), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_stall", 64'(stall_cycles), 0);
    @(posedge emu_clk);
    #1 emu_rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].mode, tbl[i].r0, tbl[i].r1, tbl[i].data);
      tick();
      chk($sformatf("v%0d_dt", i), 64'(emu_dt), 64'(tbl[i].dt));
      chk($sformatf("v%0d_time", i), emu_time, tbl[i].tm);
      if (tbl[i].chk_g) chk($sformatf("v%0d_grant", i), 64'(dt_grant), 64'(tbl[i].g));
      chk($sformatf("v%0d_running", i), 64'(running), 64'(tbl[i].run));
      chk($sformatf("v%0d_done", i), 64'(done), 64'(tbl[i].dn));
    end

    // RUN_TO with target already passed: straight to DONE, no step.
    drive(HO, 4, 4, 0); tick(); tick();
    drive(RT, 4, 4, 40); tick(); tick();
    chk("rt_past_done", 64'(done), 1);
    chk("rt_past_dt", 64'(emu_dt), 0);
    chk("rt_past_time", emu_time, 48);
    chk("rt_past_running", 64'(running), 0);
    tick();
    chk("rt_past_done_pulse", 64'(done), 0);

    // RUN_N with a zero count: straight to DONE.
    drive(HO, 4, 4, 0); tick(); tick();
    drive(RN, 4, 4, 0); tick(); tick();
    chk("rn_zero_done", 64'(done), 1);
    chk("rn_zero_time", emu_time, 48);
    tick();
    chk("rn_zero_done_pulse", 64'(done), 0);
    chk("rn_zero_running", 64'(running), 0);

    // Far target: remaining distance exceeds the dt width and must clamp, not truncate.
    far_tgt = 64'd48 + 64'h1_0000_0005;
    drive(HO, 100, 200, 0); tick(); tick();
    drive(RT, 100, 200, far_tgt); tick(); tick(); tick();
    chk("clamp_dt", 64'(emu_dt), 100);
    chk("clamp_time", emu_time, 148);
    chk("clamp_grant", 64'(dt_grant), 1);

    // Asynchronous reset in the middle of RUN_N with two steps left.
    drive(HO, 5, 5, 0); tick(); tick();
    drive(RN, 5, 5, 3); tick(); tick(); tick();
    chk("rn_mid_dt", 64'(emu_dt), 5);
    chk("rn_mid_running", 64'(running), 1);
    #2 emu_rst = 1'b1;
    #1;
    chk("arst_dt", 64'(emu_dt), 0);
    chk("arst_time", emu_time, 0);
    chk("arst_grant", 64'(dt_grant), 0);
    chk("arst_running", 64'(running), 0);
    drive(HO, 5, 5, 0);
    tick();
    emu_rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("post_rst%0d_dt", k), 64'(emu_dt), 0);
      chk($sformatf("post_rst%0d_running", k), 64'(running), 0);
      chk($sformatf("post_rst%0d_time", k), emu_time, 0);
    end
    chk("post_rst_stall", 64'(stall_cycles), 0);

    // Random phase from the idle post-reset state.
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) ctrl_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0)
        cur_r0 = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 20);
      if ($urandom_range(0, 2) == 0)
        cur_r1 = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 20);
      if (ctrl_mode == RT) begin
        if ($urandom_range(0, 4) == 0)
          ctrl_data = (m_time > 20) ? m_time - $urandom_range(0, 20) : 0;
        else
          ctrl_data = m_time + $urandom_range(1, 80);
      end else begin
        ctrl_data = 64'($urandom_range(0, 6));
      end
      model_edge();
      tick();
`ifdef EMU_DT_SCHED_STATS_EN
      exp_stall = m_stall;
`else
      exp_stall = 0;
`endif
      chk("rnd_dt", 64'(emu_dt), 64'(m_dt));
      chk("rnd_time", emu_time, m_time);
      if (m_gchk) chk("rnd_grant", 64'(dt_grant), 64'(m_grant));
      chk("rnd_running", 64'(running), 64'(m_run));
      chk("rnd_done", 64'(done), 64'(m_done));
      chk("rnd_stall", 64'(stall_cycles), 64'(exp_stall));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/emu_dt_sched.md
# emu_dt_sched

Emulation time-step scheduler. Collects step-size requests from N emulation requesters (oscillators, stall logic, models), selects the smallest, and gates stepping according to a host control mode: free-run, hold, run-to-time, or run-N-steps. It owns the emulation time accumulator and the per-cycle `emu_dt` broadcast, and sits between the oscillator/stall request sources and the model and trace logic in the emulator top.

## Interface
Parameters:
- `N_REQ`, default 2: number of dt requesters, ≥1.
- `DT_WIDTH`, default 32: width of each dt request and of `emu_dt`.
- `TIME_WIDTH`, default 64: width of `emu_time` and `ctrl_data`.

Ports:
- `emu_clk`, in, 1: emulation clock.
- `emu_rst`, in, 1: reset, asynchronous, active-high.
- `dt_req`, in, `N_REQ*DT_WIDTH`: packed requests; requester i occupies bits `[i*DT_WIDTH +: DT_WIDTH]`; unsigned.
- `ctrl_mode`, in, 2: 0 = FREE, 1 = HOLD, 2 = RUN_TO, 3 = RUN_N.
- `ctrl_data`, in, `TIME_WIDTH`: target time (RUN_TO) or step count (RUN_N); sampled only on arm.
- `emu_dt`, out, `DT_WIDTH`: step applied this cycle; registered.
- `emu_time`, out, `TIME_WIDTH`: accumulated time; registered.
- `dt_grant`, out, `N_REQ`: one-hot, the requester that set `emu_dt`; all-zero when `emu_dt` = 0 due to gating.
- `running`, out, 1: high in the FREE, RUN_TO and RUN_N states.
- `done`, out, 1: one-cycle pulse on entering DONE.
- `stall_cycles`, out, 32: count of gated cycles (see Configuration).

## Operation
- Min-select: `dmin` = minimum over `dt_req`. Ties go to the lowest index. Purely combinational within the cycle.
- States:
  - IDLE: after reset.
  - ARM: one cycle, re-latches on any mode change.
  - FREE, HOLD, RUN_TO, RUN_N, DONE.
- Mode change:
  - A registered copy `mode_q` of `ctrl_mode` is kept.
  - If `ctrl_mode != mode_q`, the next state is ARM. A change from IDLE counts as a change.
  - In ARM: `mode_q <= ctrl_mode`; `tgt <= ctrl_data` (RUN_TO) or `cnt <= ctrl_data` (RUN_N); the applied step is 0.
  - The next state follows `mode_q`.
- Applied step `dsel` per state:
  - FREE: `dmin`.
  - HOLD, IDLE, ARM, DONE: 0.
  - RUN_TO: `min(dmin, tgt - emu_time)`. Enter DONE when `emu_time + dsel == tgt`.
  - RUN_N: `dmin` while `cnt != 0`, with `cnt` decrementing on each cycle where `dsel != 0`. Enter DONE when `cnt` transitions 1→0. A zero-dt cycle does not consume a step.
- RUN_TO with `tgt <= emu_time` at arm: go directly to DONE with 0 steps taken. RUN_N with `ctrl_data` = 0 at arm: same.
- Any requester at 0 makes `dmin` = 0: time holds, `dt_grant` points to that requester, and no step is consumed.
- DONE persists until `ctrl_mode` changes. Rewriting the same mode does not re-arm; software goes via HOLD.
- Width rule: `tgt - emu_time` is computed at `TIME_WIDTH`. If it exceeds `2^DT_WIDTH - 1`, it is clamped to all-ones before the min.
- `emu_time` wraps modulo `2^TIME_WIDTH`. There is no overflow flag.

## Timing
- Each rising edge: `emu_dt <= dsel`; `emu_time <= emu_time + dsel`; `dt_grant` is registered with them. `emu_time` and `emu_dt` therefore change on the same edge, and `emu_time` already includes `emu_dt`.
- Latency: one cycle from a `dt_req` change to `emu_dt`. Two cycles from a `ctrl_mode` change to the first nonzero step (one IDLE/previous-state edge, then ARM).
- `done` is asserted on the edge entering DONE and deasserts the following edge.
- Reset (asynchronous, at any time, including mid-RUN_N):
  - `emu_dt` = 0, `emu_time` = 0, `dt_grant` = 0, `running` = 0, `done` = 0, `stall_cycles` = 0.
  - State = IDLE, `mode_q` = HOLD, `cnt` = 0, `tgt` = 0.
  - On release, the first edge compares `ctrl_mode` against HOLD. With FREE applied it re-arms; with HOLD applied it stays IDLE.

## Configuration
- `EMU_DT_SCHED_STATS_EN` defined: `stall_cycles` increments, saturating at `0xFFFF_FFFF`, on every edge where `dsel` = 0 while the state is not IDLE. It clears only on reset.
- Not defined: `stall_cycles` is tied to 0 and no counter is synthesized. All other behaviour is identical.

## Test plan
- Reset, `ctrl_mode` = FREE, `dt_req` = {10, 4} (N_REQ = 2): after the ARM cycle, `emu_dt` = 4 and `dt_grant` = 2'b10 each cycle; `emu_time` = 4, 8, 12…
- Tie `dt_req` = {7, 7}: `dt_grant` = 2'b01; then set req0 = 0: `emu_dt` = 0, `emu_time` holds, `dt_grant` = 2'b01.
- HOLD, then RUN_TO with `ctrl_data` = 10 and `dt_req` = {4, 4}: steps 4, 4, 2; `emu_time` = 10; one-cycle `done`; `running` drops; time holds in DONE.
- RUN_N with `ctrl_data` = 3 and req0 toggling between 5 and 0: exactly three nonzero steps of 5, `emu_time` +15, and `done` on the third.
- Assert `emu_rst` mid-RUN_N (with `cnt` = 2): outputs go 0 asynchronously; after release with HOLD applied, the block stays IDLE and `emu_dt` = 0.
- With `EMU_DT_SCHED_STATS_EN`: 5 HOLD cycles after arm give `stall_cycles` = 5. Without the macro, it reads 0.
